// File: rtl/mult_hilo_unit_pkg.sv
// mult_hilo_unit_pkg
//   Shared definitions for the HI/LO result stage: operation codes, FSM
//   states and default datapath widths.
//   Optional feature macro used by the slice: MULT_HILO_MACC_EN.
package mult_hilo_unit_pkg;

    localparam int unsigned DW_DEF = 16;
    localparam int unsigned PW_DEF = 32;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_MUL  = 3'b001,
        OP_MADD = 3'b010,
        OP_MSUB = 3'b011,
        OP_MTHI = 3'b100,
        OP_MTLO = 3'b101,
        OP_CLR  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mult_hilo_unit_hilo_acc.sv
// hilo_acc
//   Combinational PW-bit add/subtract of the HI/LO pair and the product.
//   Subtract is done as acc + ~product + 1; flag is the carry out for an
//   add and the borrow (acc < product) for a subtract.
//   Ports:
//     acc     in  PW  current {hi,lo}
//     product in  PW  multiplier product
//     sub     in  1   1 = subtract, 0 = add
//     result  out PW  acc +/- product, modulo 2^PW
//     flag    out 1   carry (add) or borrow (subtract)
//   Only built when MULT_HILO_MACC_EN is defined.
`ifdef MULT_HILO_MACC_EN
module hilo_acc #(
    parameter int unsigned PW = 32
)(
    input  logic [PW-1:0] acc,
    input  logic [PW-1:0] product,
    input  logic          sub,
    output logic [PW-1:0] result,
    output logic          flag
);

    logic [PW-1:0] b_op;
    logic [PW:0]   sum;

    always_comb begin
        b_op   = sub ? ~product : product;
        sum    = {1'b0, acc} + {1'b0, b_op} + {{PW{1'b0}}, sub};
        result = sum[PW-1:0];
        // With the inverted operand, a missing carry means a borrow.
        flag   = sub ? ~sum[PW] : sum[PW];
    end

endmodule
`endif

// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit
//   Sequential HI/LO result stage behind an external combinational
//   DW x DW multiplier. Accepts requests over valid/ready, drives the
//   multiplier operands, waits MULT_LAT cycles, then writes, accumulates
//   or subtracts the product into HI/LO.
//   Ports:
//     clk, rst            clock (rising edge), async active-high reset
//     req_valid/req_ready request handshake
//     req_op, req_a/b     opcode and operands (req_a is MTHI/MTLO data)
//     mul_a, mul_b        registered operands to the multiplier
//     mul_product         combinational product from the multiplier
//     hi, lo              architectural result registers
//     busy                multiply in flight
//     done                one-cycle pulse after an accepted op completes
//     ovf                 carry/borrow of the last accumulate op
//   Macro MULT_HILO_MACC_EN: when defined, MADD/MSUB accumulate through
//   hilo_acc; otherwise they behave as MUL and ovf is tied to 0.
module mult_hilo_unit
    import mult_hilo_unit_pkg::*;
#(
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned PW       = PW_DEF,
    parameter int unsigned MULT_LAT = 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [DW-1:0] req_a,
    input  logic [DW-1:0] req_b,
    output logic [DW-1:0] mul_a,
    output logic [DW-1:0] mul_b,
    input  logic [PW-1:0] mul_product,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    state_e     state;
    logic [2:0] cnt;

`ifdef MULT_HILO_MACC_EN
    op_e           op_q;
    logic          ovf_q;
    logic [PW-1:0] acc_sum;
    logic          acc_flag;

    hilo_acc #(
        .PW (PW)
    ) u_acc (
        .acc     ({hi, lo}),
        .product (mul_product),
        .sub     (op_q == OP_MSUB),
        .result  (acc_sum),
        .flag    (acc_flag)
    );

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            hi        <= '0;
            lo        <= '0;
`ifdef MULT_HILO_MACC_EN
            op_q      <= OP_NOP;
            ovf_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // req_ready is always 1 here, so valid alone means accept.
                    if (req_valid) begin
                        case (op_e'(req_op))
                            OP_MUL, OP_MADD, OP_MSUB: begin
                                mul_a     <= req_a;
                                mul_b     <= req_b;
                                cnt       <= 3'(MULT_LAT);
                                state     <= ST_WAIT;
                                req_ready <= 1'b0;
                                busy      <= 1'b1;
`ifdef MULT_HILO_MACC_EN
                                op_q      <= op_e'(req_op);
`endif
                            end
                            OP_MTHI: begin
                                hi   <= req_a;
                                done <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo   <= req_a;
                                done <= 1'b1;
                            end
                            OP_CLR: begin
                                hi   <= '0;
                                lo   <= '0;
                                done <= 1'b1;
`ifdef MULT_HILO_MACC_EN
                                ovf_q <= 1'b0;
`endif
                            end
                            default: done <= 1'b1;
                        endcase
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
`ifdef MULT_HILO_MACC_EN
                        case (op_q)
                            OP_MADD, OP_MSUB: begin
                                {hi, lo} <= acc_sum;
                                ovf_q    <= acc_flag;
                            end
                            default: begin
                                {hi, lo} <= mul_product;
                                ovf_q    <= 1'b0;
                            end
                        endcase
`else
                        {hi, lo} <= mul_product;
`endif
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb_mult_hilo_unit
//   Directed bench for mult_hilo_unit. Two instances: u_dut1 with
//   MULT_LAT=1 and u_dut3 with MULT_LAT=3, each fed by a behavioural
//   multiplier. Expected values are hand-computed; accumulate results
//   depend on MULT_HILO_MACC_EN.
module tb_mult_hilo_unit;

`ifdef MULT_HILO_MACC_EN
    localparam bit MACC = 1'b1;
`else
    localparam bit MACC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance with MULT_LAT = 1
    logic        v1 = 1'b0, rdy1, busy1, done1, ovf1;
    logic [2:0]  op1 = '0;
    logic [15:0] a1 = '0, b1 = '0, ma1, mb1, hi1, lo1;
    logic [31:0] p1;
    assign p1 = ma1 * mb1;

    // Instance with MULT_LAT = 3
    logic        v3 = 1'b0, rdy3, busy3, done3, ovf3;
    logic [2:0]  op3 = '0;
    logic [15:0] a3 = '0, b3 = '0, ma3, mb3, hi3, lo3;
    logic [31:0] p3;
    assign p3 = ma3 * mb3;

    mult_hilo_unit #(.DW(16), .PW(32), .MULT_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_op(op1),
        .req_a(a1), .req_b(b1), .mul_a(ma1), .mul_b(mb1), .mul_product(p1),
        .hi(hi1), .lo(lo1), .busy(busy1), .done(done1), .ovf(ovf1)
    );

    mult_hilo_unit #(.DW(16), .PW(32), .MULT_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_op(op3),
        .req_a(a3), .req_b(b3), .mul_a(ma3), .mul_b(mb3), .mul_product(p3),
        .hi(hi3), .lo(lo3), .busy(busy3), .done(done3), .ovf(ovf3)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request to u_dut1 (called #1 after a rising edge), wait
    // for acceptance and for the done pulse, each with a cycle budget.
    task automatic do_op1(input string tag, input logic [2:0] op,
                          input logic [15:0] a, input logic [15:0] b);
        int unsigned n;
        v1 = 1'b1; op1 = op; a1 = a; b1 = b;
        n = 0;
        while (!rdy1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!rdy1) check({tag, "_accept_timeout"}, 32'(rdy1), 32'd1);
        @(posedge clk); #1;
        v1 = 1'b0;
        n = 0;
        while (!done1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_done"}, 32'(done1), 32'd1);
    endtask

    initial begin : main
        int unsigned cyc;
        int unsigned done_seen;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_hi", 32'(hi1), 32'h0);
        check("rst_lo", 32'(lo1), 32'h0);
        check("rst_ready", 32'(rdy1), 32'd1);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_ovf", 32'(ovf1), 32'd0);
        check("rst_mul_a", 32'(ma1), 32'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // MUL 3*5 with MULT_LAT=1, cycle by cycle
        v1 = 1'b1; op1 = 3'b001; a1 = 16'h0003; b1 = 16'h0005;
        @(posedge clk); #1;
        v1 = 1'b0;
        check("mul_mul_a", 32'(ma1), 32'h3);
        check("mul_mul_b", 32'(mb1), 32'h5);
        check("mul_busy", 32'(busy1), 32'd1);
        check("mul_ready_low", 32'(rdy1), 32'd0);
        check("mul_done_early", 32'(done1), 32'd0);
        @(posedge clk); #1;
        check("mul_done", 32'(done1), 32'd1);
        check("mul_hilo", {hi1, lo1}, 32'h0000_000F);
        check("mul_ovf", 32'(ovf1), 32'd0);
        check("mul_ready_back", 32'(rdy1), 32'd1);
        @(posedge clk); #1;
        check("mul_done_once", 32'(done1), 32'd0);

        // MTHI then MTLO back to back
        v1 = 1'b1; op1 = 3'b100; a1 = 16'h1234;
        @(posedge clk); #1;
        check("mthi_done", 32'(done1), 32'd1);
        check("mthi_ready", 32'(rdy1), 32'd1);
        op1 = 3'b101; a1 = 16'hABCD;
        @(posedge clk); #1;
        v1 = 1'b0;
        check("mtlo_done", 32'(done1), 32'd1);
        check("mtlo_ready", 32'(rdy1), 32'd1);
        check("mt_hilo", {hi1, lo1}, 32'h1234_ABCD);

        // MADD wrapping past 2^32
        do_op1("pre_hi", 3'b100, 16'hFFFF, 16'h0);
        do_op1("pre_lo", 3'b101, 16'hFFFF, 16'h0);
        do_op1("madd", 3'b010, 16'h0001, 16'h0001);
        check("madd_hilo", {hi1, lo1}, MACC ? 32'h0000_0000 : 32'h0000_0001);
        check("madd_ovf", 32'(ovf1), MACC ? 32'd1 : 32'd0);

        // Move ops leave ovf untouched
        do_op1("mthi_keep", 3'b100, 16'h0000, 16'h0);
        check("mthi_ovf_kept", 32'(ovf1), MACC ? 32'd1 : 32'd0);

        // CLR then MSUB underflow
        do_op1("clr", 3'b110, 16'h0, 16'h0);
        check("clr_hilo", {hi1, lo1}, 32'h0);
        check("clr_ovf", 32'(ovf1), 32'd0);
        do_op1("msub", 3'b011, 16'h0002, 16'h0003);
        check("msub_hilo", {hi1, lo1}, MACC ? 32'hFFFF_FFFA : 32'h0000_0006);
        check("msub_ovf", 32'(ovf1), MACC ? 32'd1 : 32'd0);

        // Reserved opcode: NOP, operands hold
        do_op1("rsvd", 3'b111, 16'h5555, 16'hAAAA);
        check("rsvd_mul_a_hold", 32'(ma1), 32'h2);
        check("rsvd_mul_b_hold", 32'(mb1), 32'h3);
        check("rsvd_hilo", {hi1, lo1}, MACC ? 32'hFFFF_FFFA : 32'h0000_0006);

        // MULT_LAT=3: 0xFFFF*0xFFFF with a queued MTLO held behind it
        v3 = 1'b1; op3 = 3'b001; a3 = 16'hFFFF; b3 = 16'hFFFF;
        @(posedge clk); #1;
        op3 = 3'b101; a3 = 16'h0042; b3 = 16'h0;
        for (int i = 0; i < 3; i++) begin
            check("lat3_ready_low", 32'(rdy3), 32'd0);
            check("lat3_busy", 32'(busy3), 32'd1);
            check("lat3_no_done", 32'(done3), 32'd0);
            @(posedge clk); #1;
        end
        check("lat3_done", 32'(done3), 32'd1);
        check("lat3_hilo", {hi3, lo3}, 32'hFFFE_0001);
        check("lat3_ready_in_done", 32'(rdy3), 32'd1);
        @(posedge clk); #1;
        v3 = 1'b0;
        check("lat3_second_done", 32'(done3), 32'd1);
        check("lat3_second_lo", 32'(lo3), 32'h0042);
        check("lat3_second_hi", 32'(hi3), 32'hFFFE);

        // Async reset during WAIT of MUL 7*9 on u_dut3
        v3 = 1'b1; op3 = 3'b100; a3 = 16'h1111;
        @(posedge clk); #1;
        op3 = 3'b101; a3 = 16'h2222;
        @(posedge clk); #1;
        op3 = 3'b001; a3 = 16'h0007; b3 = 16'h0009;
        @(posedge clk); #1;
        v3 = 1'b0;
        check("abort_preload", {hi3, lo3}, 32'h1111_2222);
        check("abort_busy_before", 32'(busy3), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_hilo", {hi3, lo3}, 32'h0);
        check("abort_busy", 32'(busy3), 32'd0);
        check("abort_ready", 32'(rdy3), 32'd1);
        check("abort_mul_a", 32'(ma3), 32'h0);
        @(negedge clk) rst = 1'b0;
        done_seen = 0;
        for (cyc = 0; cyc < 5; cyc++) begin
            @(posedge clk); #1;
            if (done3) done_seen++;
        end
        check("abort_no_done", done_seen, 32'd0);
        check("abort_hilo_after", {hi3, lo3}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_hilo_unit.md
Name: mult_hilo_unit

Overview:
- Sequential HI/LO result stage directly downstream of the 16x16 combinational multiplier `mult`.
- Accepts multiply and move requests from the execute stage via a valid/ready handshake.
- Drives the multiplier operands, waits a fixed settle latency, then samples the 32-bit product.
- Writes, accumulates or subtracts the product into the architectural HI/LO registers.

Parameters:
- DW, 16, operand / HI / LO width.
- PW, 32, product width; must equal 2*DW.
- MULT_LAT, 1, cycles the product is allowed to settle before sampling; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  3  operation code, see Behaviour.
- req_a  in  DW  operand A; also the data source for MTHI/MTLO.
- req_b  in  DW  operand B.
- mul_a  out  DW  registered operand A to the multiplier.
- mul_b  out  DW  registered operand B to the multiplier.
- mul_product  in  PW  combinational product from the multiplier.
- hi  out  DW  HI register.
- lo  out  DW  LO register.
- busy  out  1  multiply in flight.
- done  out  1  one-cycle pulse after any accepted op completes.
- ovf  out  1  carry or borrow out of the last accumulate op.

Behaviour:
- Opcodes:
  - 000 NOP.
  - 001 MUL: {hi,lo} <= P.
  - 010 MADD: {hi,lo} <= {hi,lo} + P.
  - 011 MSUB: {hi,lo} <= {hi,lo} - P.
  - 100 MTHI: hi <= req_a.
  - 101 MTLO: lo <= req_a.
  - 110 CLR: hi, lo, ovf <= 0.
  - 111 reserved: treated as NOP.
- Reset values: hi, lo, mul_a, mul_b = 0; busy, done, ovf = 0; req_ready = 1; state IDLE; counter = 0.
- FSM state IDLE:
  - req_ready = 1.
  - Accept occurs at a rising edge with req_valid & req_ready.
  - NOP, reserved, MTHI, MTLO and CLR complete at the accept edge; done = 1 in the following cycle; state stays IDLE.
  - MUL, MADD and MSUB:
    - mul_a <= req_a, mul_b <= req_b.
    - Opcode is latched.
    - cnt <= MULT_LAT.
    - State moves to WAIT.
- FSM state WAIT:
  - req_ready = 0, busy = 1.
  - cnt decrements each edge.
  - At the edge where cnt == 1, mul_product is sampled and hi/lo are written per the latched opcode.
  - At that same edge, done <= 1 and state moves to IDLE.
- Latency: a multiply accepted at edge E0 updates hi/lo at edge E(MULT_LAT); done is high in the cycle after that edge.
- Back-to-back: a new request may be accepted in the same cycle that done is high.
- Operand hold: mul_a and mul_b hold their last values while IDLE; they change only on a multiply accept.
- Arithmetic: all arithmetic is unsigned modulo 2^PW.
  - MADD: ovf <= carry out of bit PW-1.
  - MSUB: ovf <= borrow, i.e. {hi,lo} < P before the subtract.
  - MUL: ovf <= 0.
  - Move ops leave ovf unchanged.
- Read-after-write: hi and lo are registered outputs, so a consumer sees the new value in the done cycle.
- Reset mid-operation (asynchronous): the in-flight op is aborted, no hi/lo write occurs, and all outputs return to reset values immediately.
- Requests with req_valid high while req_ready is low are not accepted; the requester must hold them stable until accepted.

Optional Feature:
- Macro: MULT_HILO_MACC_EN.
- Defined: MADD/MSUB behave as above and the add/sub datapath is instantiated.
- Undefined:
  - Opcodes 010 and 011 execute exactly as MUL; no accumulate adder is built.
  - ovf is tied to 0.

Decomposition:
- Shared header mult_defs.vh: opcode localparams (OP_NOP..OP_CLR), DW/PW defaults, FSM state encodings (IDLE, WAIT).
- One sub-module, hilo_acc: combinational PW-bit add/subtract of {hi,lo} and the product, with a carry/borrow flag.
  - Built on adder32bit with B inversion and carry-in for subtract.
  - Instantiated only under MULT_HILO_MACC_EN.

Test Plan:
- Reset then MUL a=0x0003 b=0x0005 (MULT_LAT=1) -> mul_a=3, mul_b=5 after accept; hi=0x0000, lo=0x000F one edge later; done pulses one cycle; ovf=0.
- MTHI 0x1234, then MTLO 0xABCD -> done each cycle, req_ready stays 1; hi=0x1234, lo=0xABCD.
- {hi,lo}=0xFFFFFFFF, MADD a=0x0001 b=0x0001 -> {hi,lo}=0x00000000, ovf=1.
  - Without the macro: {hi,lo}=0x00000001, ovf=0.
- {hi,lo}=0x00000000, MSUB a=0x0002 b=0x0003 -> {hi,lo}=0xFFFFFFFA, ovf=1.
- MULT_LAT=3, MUL 0xFFFF*0xFFFF with req_valid held and a second request queued:
  - req_ready=0 and busy=1 for 3 cycles.
  - Result 0xFFFE0001.
  - Second request accepted in the done cycle.
- Assert rst during WAIT of MUL 7*9 with hi/lo preloaded 0x1111/0x2222 -> hi=lo=0, busy=0, done never pulses, req_ready=1 asynchronously.
